// File: rtl/peran_pkg.sv
// Shared definitions for the peran tree-traversal processing element:
// node record field layout, record/result types and the LFSR seed byte.
package peran_pkg;

    localparam int unsigned W_NODE   = 222;
    localparam int unsigned W_ADDR   = 10;
    localparam int unsigned W_SEQ    = 32;
    localparam int unsigned W_RESULT = W_ADDR + W_SEQ;

    // Node record field positions
    localparam int ID_HI  = 221;
    localparam int ID_LO  = 212;
    localparam int C1_HI  = 211;
    localparam int C1_LO  = 202;
    localparam int C2_HI  = 201;
    localparam int C2_LO  = 192;
    localparam int SEQ_HI = 191;
    localparam int SEQ_LO = 160;
    localparam int THR_HI = 159;
    localparam int THR_LO = 152;

    // Low byte of the LFSR reset value; keeps the state non-zero for any seed
    localparam logic [7:0] LFSR_SEED = 8'h5A;

    typedef logic [W_NODE-1:0]   node_t;
    typedef logic [W_RESULT-1:0] result_t;

    // A node with no children (address 0 on both sides) is a leaf
    function automatic logic is_leaf(node_t n);
        return (n[C1_HI:C1_LO] == '0) && (n[C2_HI:C2_LO] == '0);
    endfunction

endpackage

// File: rtl/peran_lfsr.sv
// 32-bit Fibonacci LFSR that free-runs every cycle; loaded from seed_ID
// while reset is held low.
module peran_lfsr
    import peran_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  seed_ID,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    // Taps 31, 21, 1, 0 feed the new LSB
    always_comb begin
        state_d = {state_q[30:0], state_q[31] ^ state_q[21] ^ state_q[1] ^ state_q[0]};
    end

    // State register; the seed is sampled only while reset is asserted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= {seed_ID, ~seed_ID, seed_ID, LFSR_SEED};
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/peran.sv
// Tree-traversal processing element: picks a node/parent operand, applies
// one LFSR-driven point mutation to the sequence, holds the result for one
// cycle and fans it out toward the node's children (or emits a leaf result).
module peran
    import peran_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          seed_ID,
    input  logic [W_NODE-1:0]   in1,
    input  logic [W_NODE-1:0]   in2,
    output logic [W_NODE-1:0]   out1,
    output logic [W_NODE-1:0]   out2,
    output logic [W_ADDR-1:0]   child_1,
    output logic [W_ADDR-1:0]   child_2,
    output logic [W_RESULT-1:0] result,
    output logic                using,
    output logic                leaf
);

    logic [31:0]      lfsr_state;
    node_t            merge;
    node_t            evolved;
    node_t            hold_q;
    logic             mutate;
    logic [1:0]       delta;
    logic [W_SEQ-1:0] mut_mask;
    logic             unused_lfsr_hi;

    peran_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .seed_ID (seed_ID),
        .state   (lfsr_state)
    );

    // Only bits [13:0] steer the mutation; the rest just keep the sequence long
    assign unused_lfsr_hi = ^lfsr_state[31:14];

    // Operand select: node record wins, parent supplies the sequence when both
    // are present; both zero falls through to an all-zero bubble
    always_comb begin
        merge = '0;
        if ((in1 != '0) && (in2 != '0)) begin
            merge                = in1;
            merge[SEQ_HI:SEQ_LO] = in2[SEQ_HI:SEQ_LO];
        end else if (in1 != '0) begin
            merge = in1;
        end else begin
            merge = in2;
        end
    end

    // Point mutation: a zero mask is promoted to 01 so the base always changes;
    // a bubble has T = 0 and is never mutated, so it stays zero
    always_comb begin
        mutate   = lfsr_state[7:0] < merge[THR_HI:THR_LO];
        delta    = (lfsr_state[13:12] == 2'b00) ? 2'b01 : lfsr_state[13:12];
        mut_mask = mutate ? ({30'b0, delta} << {lfsr_state[11:8], 1'b0}) : '0;
        evolved  = merge;
        evolved[SEQ_HI:SEQ_LO] = merge[SEQ_HI:SEQ_LO] ^ mut_mask;
    end

    // Hold register; reset discards any in-flight record
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= evolved;
        end
    end

    // Outputs decoded from the held record; an empty hold reads all-zero
    always_comb begin
        using   = (hold_q != '0);
        leaf    = using && is_leaf(hold_q);
        child_1 = hold_q[C1_HI:C1_LO];
        child_2 = hold_q[C2_HI:C2_LO];
        out1    = (hold_q[C1_HI:C1_LO] != '0) ? hold_q : '0;
        out2    = (hold_q[C2_HI:C2_LO] != '0) ? hold_q : '0;
        result  = leaf ? {hold_q[ID_HI:ID_LO], hold_q[SEQ_HI:SEQ_LO]} : '0;
    end

endmodule

// File: tb/tb_peran.sv
// Self-checking bench for peran: directed cases plus randomized records
// compared against a field-level reference model with its own LFSR.
module tb_peran;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   seed_ID;
    logic [221:0] in1;
    logic [221:0] in2;
    logic [221:0] out1;
    logic [221:0] out2;
    logic [9:0]   child_1;
    logic [9:0]   child_2;
    logic [41:0]  result;
    logic         using;
    logic         leaf;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_lfsr;

    peran dut (
        .clk     (clk),
        .reset   (reset),
        .seed_ID (seed_ID),
        .in1     (in1),
        .in2     (in2),
        .out1    (out1),
        .out2    (out2),
        .child_1 (child_1),
        .child_2 (child_2),
        .result  (result),
        .using   (using),
        .leaf    (leaf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [221:0] got, input logic [221:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // Reference: what the hold register should contain after one edge
    function automatic logic [221:0] model_hold(input logic [221:0] a, input logic [221:0] b,
                                                input logic [31:0] l);
        logic [221:0] m;
        logic [31:0]  seq;
        int           idx;
        int           d;
        int           base;
        if (a != 0) m = a;
        else m = b;
        if (a != 0 && b != 0) m[191:160] = b[191:160];
        if (int'(l[7:0]) < int'(m[159:152])) begin
            idx  = int'(l[11:8]);
            d    = int'(l[13:12]);
            if (d == 0) d = 1;
            seq  = m[191:160];
            base = int'((seq >> (2 * idx)) & 32'd3);
            seq  = (seq & ~(32'd3 << (2 * idx))) | (32'(base ^ d) << (2 * idx));
            m[191:160] = seq;
        end
        return m;
    endfunction

    function automatic logic [221:0] mk(input int id, input int c1, input int c2,
                                        input logic [31:0] seq, input logic [7:0] thr);
        logic [159:0] rsv;
        rsv = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return {10'(id), 10'(c1), 10'(c2), seq, thr, rsv[151:0]};
    endfunction

    function automatic logic [221:0] rand_rec();
        int c1;
        int c2;
        c1 = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 1023));
        c2 = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 1023));
        return mk(int'($urandom_range(0, 1023)), c1, c2, $urandom, 8'($urandom));
    endfunction

    // Drive one cycle of inputs, advance the model alongside the DUT
    task automatic step(input logic [221:0] a, input logic [221:0] b, output logic [221:0] h);
        in1 = a;
        in2 = b;
        @(posedge clk);
        h      = model_hold(a, b, m_lfsr);
        m_lfsr = lfsr_next(m_lfsr);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [221:0] h);
        logic u;
        logic lf;
        u  = (h != 0);
        lf = u && (h[211:202] == 0) && (h[201:192] == 0);
        check({tag, ".using"}, 222'(using), 222'(u));
        check({tag, ".leaf"}, 222'(leaf), 222'(lf));
        check({tag, ".child_1"}, 222'(child_1), 222'(h[211:202]));
        check({tag, ".child_2"}, 222'(child_2), 222'(h[201:192]));
        check({tag, ".out1"}, out1, (h[211:202] != 0) ? h : 222'(0));
        check({tag, ".out2"}, out2, (h[201:192] != 0) ? h : 222'(0));
        check({tag, ".result"}, 222'(result), lf ? 222'({h[221:212], h[191:160]}) : 222'(0));
    endtask

    task automatic do_reset(input logic [7:0] s);
        reset   = 1'b0;
        seed_ID = s;
        in1     = '0;
        in2     = '0;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        m_lfsr = {s, ~s, s, 8'h5A};
    endtask

    logic [221:0] h;
    logic [221:0] a;
    logic [221:0] s1 [40];
    logic [221:0] s2 [40];
    logic [221:0] rec_o1 [40];
    logic [221:0] rec_o2 [40];
    logic [41:0]  rec_res [40];

    initial begin
        // Reset state
        do_reset(8'h3C);
        #1;
        check_outs("reset", 222'(0));
        check("reset.lfsr", 222'(dut.lfsr_state), 222'(32'h3CC33C5A));

        // Internal node, no mutation: forwarded to both children
        a = mk(5, 7, 9, 32'hDEADBEEF, 8'h00);
        step(a, 222'(0), h);
        check_outs("inner", h);
        check("inner.out1_is_in1", out1, a);
        check("inner.out2_is_in1", out2, a);

        // Leaf with parent sequence substituted
        a = mk(12, 0, 0, 32'hCAFEF00D, 8'h00);
        step(a, mk(3, 4, 5, 32'h12345678, 8'h00), h);
        check_outs("leafmerge", h);
        check("leafmerge.result", 222'(result), 222'({10'd12, 32'h12345678}));

        // Always-mutate leaves: exactly one base changes unless L[7:0] is FF
        for (int i = 0; i < 100; i++) begin
            logic [31:0] l_used;
            logic [31:0] seq_in;
            int          ndiff;
            seq_in = $urandom;
            l_used = m_lfsr;
            a      = mk(int'($urandom_range(1, 1023)), 0, 0, seq_in, 8'hFF);
            step(a, 222'(0), h);
            check("mut.result", 222'(result), 222'({h[221:212], h[191:160]}));
            ndiff = 0;
            for (int k = 0; k < 16; k++) begin
                if (result[2*k +: 2] != seq_in[2*k +: 2]) ndiff++;
            end
            check("mut.ndiff", 222'(ndiff), (l_used[7:0] == 8'hFF) ? 222'(0) : 222'(1));
        end
        check("mut.lfsr_track", 222'(dut.lfsr_state), 222'(m_lfsr));

        // Bubble after a valid record
        step(mk(20, 1, 2, $urandom, 8'h80), 222'(0), h);
        check_outs("prebubble", h);
        step(222'(0), 222'(0), h);
        check_outs("bubble", h);

        // Randomized mix of node/parent/bubble cycles, recorded for replay
        for (int i = 0; i < 40; i++) begin
            s1[i] = ($urandom_range(0, 3) == 0) ? 222'(0) : rand_rec();
            s2[i] = ($urandom_range(0, 1) == 0) ? 222'(0) : rand_rec();
        end
        s1[19] = mk(77, 3, 0, $urandom, 8'h40);
        do_reset(8'hA7);
        for (int i = 0; i < 40; i++) begin
            step(s1[i], s2[i], h);
            check_outs("rand", h);
            rec_o1[i]  = out1;
            rec_o2[i]  = out2;
            rec_res[i] = result;
        end

        // Async reset while a record is held
        do_reset(8'hA7);
        for (int i = 0; i < 20; i++) begin
            step(s1[i], s2[i], h);
        end
        check("midrst.using_before", 222'(using), 222'(1));
        #2;
        reset = 1'b0;
        #1;
        check_outs("midrst", 222'(0));
        seed_ID = 8'hA7;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        m_lfsr = {8'hA7, ~8'hA7, 8'hA7, 8'h5A};

        // Replay must reproduce the first run bit-for-bit
        for (int i = 0; i < 40; i++) begin
            step(s1[i], s2[i], h);
            check("replay.out1", out1, rec_o1[i]);
            check("replay.out2", out2, rec_o2[i]);
            check("replay.result", 222'(result), 222'(rec_res[i]));
            check("replay.model", out1, (h[211:202] != 0) ? h : 222'(0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
